// File: rtl/pcm_period_buffer_if.sv
// Sample/duty bus between the decimator, the period buffer and the PWM stage.
// Optional volume_i exists only when PCM_VOLUME_EN is defined.
interface pcm_period_buffer_if #(
  parameter int FIFO_DEPTH = 16
);
  logic                          enable_i;
  logic signed [15:0]            sample_i;
  logic                          sample_valid_i;
  logic                          sample_ready_o;
`ifdef PCM_VOLUME_EN
  logic [3:0]                    volume_i;
`endif
  logic [7:0]                    pcm_o;
  logic                          pcm_update_o;
  logic                          underflow_o;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count_o;

`ifdef PCM_VOLUME_EN
  modport master (
    output enable_i, sample_i, sample_valid_i, volume_i,
    input  sample_ready_o, pcm_o, pcm_update_o, underflow_o, fifo_count_o
  );
  modport slave (
    input  enable_i, sample_i, sample_valid_i, volume_i,
    output sample_ready_o, pcm_o, pcm_update_o, underflow_o, fifo_count_o
  );
`else
  modport master (
    output enable_i, sample_i, sample_valid_i,
    input  sample_ready_o, pcm_o, pcm_update_o, underflow_o, fifo_count_o
  );
  modport slave (
    input  enable_i, sample_i, sample_valid_i,
    output sample_ready_o, pcm_o, pcm_update_o, underflow_o, fifo_count_o
  );
`endif
endinterface

// File: rtl/pcm_period_buffer.sv
// Sample FIFO feeding the PWM stage one offset-binary duty code per PWM period.
// Optional gain/saturation stage enabled by defining PCM_VOLUME_EN.
module pcm_period_buffer #(
  parameter int FIFO_DEPTH = 16,
  parameter int PERIOD     = 256
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pcm_period_buffer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(PERIOD);
  localparam int NW = AW + 1;

`ifdef PCM_VOLUME_EN
  function automatic logic [7:0] to_duty(input logic signed [15:0] s, input logic [3:0] vol);
    logic signed [30:0] g;
    logic signed [15:0] sat;
    g = {{15{s[15]}}, s} <<< vol;
    if (g > 31'sd32767)
      sat = 16'sh7FFF;
    else if (g < -31'sd32768)
      sat = 16'sh8000;
    else
      sat = g[15:0];
    return 8'({~sat[15], sat[14:0]} >> 8);
  endfunction
`else
  function automatic logic [7:0] to_duty(input logic signed [15:0] s);
    return 8'({~s[15], s[14:0]} >> 8);
  endfunction
`endif

  logic signed [15:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [NW-1:0]      count_q, count_d;
  logic [CW-1:0]      cnt_q;
  logic [7:0]         pcm_q, pcm_d;
  logic               upd_q, unf_q, ready_q;
  logic               ready, push, pop, boundary, empty;

  // Ready depends only on registered occupancy, so a pop cannot make room in the same cycle.
  assign ready    = bus.enable_i && ready_q;
  assign push     = bus.sample_valid_i && ready;
  assign empty    = (count_q == '0);
  assign boundary = bus.enable_i && (cnt_q == CW'(PERIOD - 1));
  assign pop      = boundary && !empty;
  assign count_d  = count_q + NW'(push) - NW'(pop);

`ifdef PCM_VOLUME_EN
  assign pcm_d = to_duty(mem_q[rd_ptr_q], bus.volume_i);
`else
  assign pcm_d = to_duty(mem_q[rd_ptr_q]);
`endif

  always_ff @(posedge clk_i) begin
    if (push)
      mem_q[wr_ptr_q] <= bus.sample_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pcm_q    <= 8'h80;
      upd_q    <= 1'b0;
      unf_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else if (!bus.enable_i) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pcm_q    <= 8'h80;
      upd_q    <= 1'b0;
      unf_q    <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      cnt_q   <= (cnt_q == CW'(PERIOD - 1)) ? '0 : cnt_q + 1'b1;
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        pcm_q    <= pcm_d;
      end
      if (boundary && empty)
        unf_q <= 1'b1;
      upd_q   <= boundary;
      count_q <= count_d;
      ready_q <= (count_d != NW'(FIFO_DEPTH));
    end
  end

  assign bus.sample_ready_o = ready;
  assign bus.pcm_o          = pcm_q;
  assign bus.pcm_update_o   = upd_q;
  assign bus.underflow_o    = unf_q;
  assign bus.fifo_count_o   = count_q;
endmodule
